// File: rtl/mux_sel_buf_pkg.sv
// Shared definitions for the register-destination/operand selector with output buffer.
// Holds the selector encodings and the default hard-wired register indices.
package mux_sel_buf_pkg;

    localparam int unsigned SP_IDX    = 29;
    localparam int unsigned RA_IDX    = 31;
    localparam int unsigned SEL_DATA0 = 0;

    typedef enum logic [1:0] {
        SEL_KIND_DATA,
        SEL_KIND_CONST_A,
        SEL_KIND_CONST_B,
        SEL_KIND_ILLEGAL
    } sel_kind_e;

    // Constant selectors sit directly above the data inputs.
    function automatic int unsigned sel_const_a(input int unsigned n_data);
        return n_data;
    endfunction

    function automatic int unsigned sel_const_b(input int unsigned n_data);
        return n_data + 1;
    endfunction

    function automatic sel_kind_e classify_sel(input int unsigned sel, input int unsigned n_data);
        if (sel < n_data) begin
            return SEL_KIND_DATA;
        end else if (sel == sel_const_a(n_data)) begin
            return SEL_KIND_CONST_A;
        end else if (sel == sel_const_b(n_data)) begin
            return SEL_KIND_CONST_B;
        end
        return SEL_KIND_ILLEGAL;
    endfunction

endpackage

// File: rtl/mux_sel_buf_sel_fifo.sv
// Small FIFO with valid/ready on both sides; any DEPTH, pointers wrap at DEPTH-1.
// in_ready and out_valid are flops so neither side sees a combinational path from the other.
module sel_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       out_valid,
    input  logic                       pop_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             push;
    logic             pop;

    assign push    = push_valid && in_ready;
    assign pop     = out_valid && pop_ready;
    assign rd_data = mem[rd_ptr];

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (push) begin
            wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            in_ready  <= (count_nxt < CNT_W'(DEPTH));
            out_valid <= (count_nxt != '0);
        end
    end

    // Storage is cleared on reset so the head never reads X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/mux_sel_buf.sv
// Operand / destination selector: picks a data input or a hard register index,
// buffers it in sel_fifo and flags out-of-range selector codes.
module mux_sel_buf
    import mux_sel_buf_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_DATA  = 3,
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned CONST_A = SP_IDX,
    parameter int unsigned CONST_B = RA_IDX,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SEL_W-1:0]           sel,
    input  logic [N_DATA*WIDTH-1:0]    data_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           data_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       illegal_sel,
    input  logic                       clr_err
);

    logic [WIDTH-1:0] sel_data_c;
    logic             sel_illegal_c;
    logic             push;

    assign push = in_valid && in_ready;

    // Source selection; illegal codes fall back to data_0.
    always_comb begin
        sel_data_c    = data_in[WIDTH-1:0];
        sel_illegal_c = 1'b0;
        case (classify_sel(32'(sel), N_DATA))
            SEL_KIND_DATA: begin
                for (int unsigned k = SEL_DATA0; k < N_DATA; k++) begin
                    if (32'(sel) == k) begin
                        sel_data_c = data_in[k*WIDTH +: WIDTH];
                    end
                end
            end
            SEL_KIND_CONST_A: sel_data_c = WIDTH'(CONST_A);
            SEL_KIND_CONST_B: sel_data_c = WIDTH'(CONST_B);
            default:          sel_illegal_c = 1'b1;
        endcase
    end

    // Sticky error flag; a new illegal accept outranks clr_err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_sel <= 1'b0;
        end else if (push && sel_illegal_c) begin
            illegal_sel <= 1'b1;
        end else if (clr_err) begin
            illegal_sel <= 1'b0;
        end
    end

    sel_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (in_valid),
        .wr_data    (sel_data_c),
        .in_ready   (in_ready),
        .rd_data    (data_out),
        .out_valid  (out_valid),
        .pop_ready  (out_ready),
        .count      (count)
    );

endmodule

// File: tb/tb_mux_sel_buf.sv
// Directed bench for mux_sel_buf: DEPTH=2 main instance plus a DEPTH=3 instance for pointer wrap.
// Expected words are queued at accept time and compared when the consumer takes them.
module tb_mux_sel_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sel;
    logic [95:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  count;
    logic        illegal_sel;
    logic        clr_err;

    logic [2:0]  sel3;
    logic [95:0] data_in3;
    logic        in_valid3;
    logic        in_ready3;
    logic [31:0] data_out3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  count3;
    logic        illegal3;

    logic [31:0] q[$];
    logic [31:0] q3[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mux_sel_buf u_dut (
        .clk         (clk),
        .reset       (reset),
        .sel         (sel),
        .data_in     (data_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .illegal_sel (illegal_sel),
        .clr_err     (clr_err)
    );

    mux_sel_buf #(.DEPTH(3)) u_dut3 (
        .clk         (clk),
        .reset       (reset),
        .sel         (sel3),
        .data_in     (data_in3),
        .in_valid    (in_valid3),
        .in_ready    (in_ready3),
        .data_out    (data_out3),
        .out_valid   (out_valid3),
        .out_ready   (out_ready3),
        .count       (count3),
        .illegal_sel (illegal3),
        .clr_err     (1'b0)
    );

    function automatic logic [31:0] model(input logic [2:0] s, input logic [95:0] d);
        case (s)
            3'd0:    return d[31:0];
            3'd1:    return d[63:32];
            3'd2:    return d[95:64];
            3'd3:    return 32'd29;
            3'd4:    return 32'd31;
            default: return d[31:0];
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Account for the coming edge using the settled pre-edge handshake values.
    task automatic cycle();
        #1;
        if (in_valid && in_ready)   q.push_back(model(sel, data_in));
        if (in_valid3 && in_ready3) q3.push_back(model(sel3, data_in3));
        if (out_valid && out_ready) begin
            if (q.size() == 0) check("sb_underflow", 64'(out_valid), 64'd0);
            else               check("sb_data", 64'(data_out), 64'(q.pop_front()));
        end
        if (out_valid3 && out_ready3) begin
            if (q3.size() == 0) check("sb3_underflow", 64'(out_valid3), 64'd0);
            else                check("sb3_data", 64'(data_out3), 64'(q3.pop_front()));
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        sel        = 3'd0;
        data_in    = {32'h333, 32'h222, 32'h111};
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        clr_err    = 1'b0;
        sel3       = 3'd0;
        data_in3   = '0;
        in_valid3  = 1'b0;
        out_ready3 = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_count",     64'(count),       64'd0);
        check("rst_out_valid", 64'(out_valid),   64'd0);
        check("rst_in_ready",  64'(in_ready),    64'd1);
        check("rst_illegal",   64'(illegal_sel), 64'd0);
        check("rst_data_out",  64'(data_out),    64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Plain data selects streamed with out_ready high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel = 3'(i);
            cycle();
            check("lat_out_valid", 64'(out_valid), 64'd1);
            check("lat_count",     64'(count),     64'd1);
        end
        in_valid = 1'b0;
        cycle();
        check("drain_count", 64'(count), 64'd0);

        // Constant selects.
        in_valid = 1'b1;
        sel = 3'd3;
        cycle();
        check("const_a_head", 64'(data_out), 64'h1d);
        sel = 3'd4;
        cycle();
        check("const_b_head", 64'(data_out), 64'h1f);
        in_valid = 1'b0;
        cycle();
        check("const_illegal", 64'(illegal_sel), 64'd0);

        // Fill while stalled, then release.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel = 3'd0; cycle();
        sel = 3'd1; cycle();
        check("full_count",    64'(count),    64'd2);
        check("full_in_ready", 64'(in_ready), 64'd0);
        sel = 3'd2; cycle();
        check("full_refuse_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        check("full_pop_head", 64'(data_out), 64'h111);
        cycle();
        check("after_pop_count",    64'(count),    64'd1);
        check("after_pop_in_ready", 64'(in_ready), 64'd1);
        cycle();
        in_valid = 1'b0;
        check("third_accept_count", 64'(count), 64'd1);
        cycle();
        check("fill_drain_count", 64'(count), 64'd0);

        // Illegal selector: sticky flag and clear priority.
        in_valid = 1'b1;
        sel = 3'd7;
        cycle();
        check("illegal_set",  64'(illegal_sel), 64'd1);
        check("illegal_head", 64'(data_out),    64'h111);
        for (int i = 0; i < 5; i++) begin
            sel = 3'(i);
            cycle();
            check("illegal_sticky", 64'(illegal_sel), 64'd1);
        end
        in_valid = 1'b0;
        clr_err  = 1'b1;
        cycle();
        clr_err = 1'b0;
        check("illegal_clear", 64'(illegal_sel), 64'd0);
        clr_err  = 1'b1;
        in_valid = 1'b1;
        sel = 3'd7;
        cycle();
        clr_err  = 1'b0;
        in_valid = 1'b0;
        check("illegal_set_wins", 64'(illegal_sel), 64'd1);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel = 3'd0; cycle();
        sel = 3'd1; cycle();
        sel = 3'd7; cycle();
        check("illegal_refused", 64'(illegal_sel), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();
        check("illegal_drain", 64'(count), 64'd0);

        // Steady simultaneous push/pop.
        in_valid = 1'b1;
        sel = 3'd0;
        cycle();
        for (int i = 0; i < 10; i++) begin
            data_in = {$urandom, $urandom, $urandom};
            sel     = 3'($urandom_range(0, 4));
            cycle();
            check("stream_count", 64'(count), 64'd1);
        end
        in_valid = 1'b0;
        cycle();
        check("stream_drain", 64'(count), 64'd0);

        // DEPTH=3 instance: fill, then stream to wrap pointers repeatedly.
        in_valid3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in3 = {$urandom, $urandom, $urandom};
            sel3     = 3'($urandom_range(0, 4));
            cycle();
        end
        check("d3_full_count",    64'(count3),    64'd3);
        check("d3_full_in_ready", 64'(in_ready3), 64'd0);
        out_ready3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in3 = {$urandom, $urandom, $urandom};
            sel3     = 3'($urandom_range(0, 4));
            cycle();
        end
        check("d3_stream_count", 64'(count3), 64'd2);
        in_valid3 = 1'b0;
        cycle();
        cycle();
        check("d3_drain_count", 64'(count3), 64'd0);
        out_ready3 = 1'b0;

        // Asynchronous reset while holding two entries.
        data_in   = {32'h333, 32'h222, 32'h111};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel = 3'd0; cycle();
        sel = 3'd1; cycle();
        in_valid = 1'b0;
        check("pre_rst_count", 64'(count), 64'd2);
        reset = 1'b1;
        #1;
        check("async_rst_count",     64'(count),     64'd0);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready",  64'(in_ready),  64'd1);
        q.delete();
        q3.delete();
        #3;
        reset = 1'b0;
        @(negedge clk);
        data_in   = {32'h666, 32'h555, 32'h444};
        sel       = 3'd2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("post_rst_count", 64'(count),    64'd1);
        check("post_rst_head",  64'(data_out), 64'h666);
        cycle();

        check("sb_leftover",  64'(q.size()),  64'd0);
        check("sb3_leftover", 64'(q3.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
